normalize_shifter: RTL and testbench
====================================

Name: normalize_shifter

Overview:
- Pipelined normalization left-shifter; consumes the leading-zero count produced by the leading-zeros detector tree.
- Shifts the significand so its MSB is 1, and decrements the exponent by the applied shift.
- Clamps the shift at the minimum exponent, giving a denormal result.
- Sits after the LZD in add/sub and convert paths; valid/ready on both sides.

Parameters:
- WIDTH, 32, significand width; power of two.
- CNT_W, $clog2(WIDTH), shift-count width (5 at default).
- EXP_W, 10, signed exponent width.
- EXP_MIN, -126, minimum normal exponent; shifts never push the exponent below it.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- in_significand  in  WIDTH  unnormalized significand.
- in_exponent  in  EXP_W  signed exponent.
- in_lz_count  in  CNT_W  leading-zero count from the LZD.
- in_all_zero  in  1  LZD all-zeros flag; when set, in_lz_count is don't-care.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_significand  out  WIDTH  normalized significand.
- out_exponent  out  EXP_W  adjusted signed exponent.
- out_zero  out  1  result is zero.
- out_denormal  out  1  shift was clamped by EXP_MIN.

Behaviour:
- Reset: out_valid=0, all data outputs and flags 0, internal valids 0. Reset mid-operation discards in-flight beats. in_ready is 1 in the first cycle after reset deasserts.
- Pipeline: 2 stages; latency is exactly 2 cycles from acceptance when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - Accept when in_valid && in_ready; output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. in_ready is combinational from out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - Beats are never dropped, duplicated or reordered.
- Stage 1, computed at acceptance:
  - headroom = in_exponent - EXP_MIN, computed at EXP_W+1 bits signed.
  - If headroom <= 0: amt = 0, denormal = 1.
  - Else if lz > headroom: amt = headroom, denormal = 1.
  - Else: amt = lz, denormal = 0.
  - exp1 = in_exponent - amt.
  - Coarse shift: sig1 = in_significand << {amt[CNT_W-1:3], 3'b0}.
  - Register sig1, amt[2:0], exp1, denormal and zero.
- Stage 2: out_significand = sig1 << amt[2:0]; exponent and flags pass through.
- in_all_zero=1 gives out_significand=0, out_exponent=0, out_zero=1, out_denormal=0.
- Arithmetic:
  - The exponent subtract never wraps, because clamping guarantees out_exponent >= EXP_MIN whenever in_exponent >= EXP_MIN.
  - If in_exponent < EXP_MIN, the exponent passes through unchanged with denormal=1.
- A lz count of 0 with a set MSB passes the data through unshifted.

Optional Feature:
- Macro NORM_STATS_EN.
- When defined:
  - Adds outputs stat_zero_count[15:0] and stat_denormal_count[15:0].
  - Each counter increments on every output transfer with out_zero or out_denormal respectively, and saturates at 16'hFFFF.
  - Both counters are cleared by reset and by an added input stat_clear (synchronous, 1 cycle). If stat_clear coincides with an increment, the clear wins.
- When undefined: no stat ports, no counters. Datapath behaviour is identical either way.

Decomposition:
- Shared fpu package holds:
  - a norm_beat_t struct {significand, exponent, zero, denormal};
  - WIDTH, CNT_W, EXP_W and EXP_MIN as package constants, reused by the LZD tree.
- One natural sub-module: norm_shift_amount, the combinational clamp and amount calculator used by stage 1. The pipeline registers and handshake stay in the top.

Test Plan:
- Basic shift: sig=32'h0000_1234, lz=19, exp=0 -> two cycles later sig=32'h91A0_0000, exp=-19, zero=0, denormal=0.
- Clamp: sig=32'h0000_0001, lz=31, exp=-120 -> sig=32'h0000_0040, exp=-126, denormal=1.
- Zero input: in_all_zero=1, sig=0, exp=5 -> sig=0, exp=0, zero=1, denormal=0.
- Backpressure:
  - Drive 4 back-to-back beats with lz=0,1,2,3 while out_ready=0.
  - Required: in_ready falls after 2 accepted beats, outputs stay frozen, and once out_ready=1 all 4 results emerge in order.
- Reset mid-flight: assert reset with 2 beats in flight -> out_valid=0 immediately, outputs 0, no stale beat after release.
- NORM_STATS_EN:
  - Send 3 zero beats and 2 clamped beats -> counters read 3 and 2.
  - Preload to 16'hFFFF -> counter holds at 16'hFFFF.
  - stat_clear coinciding with an increment -> counter reads 0.

Source files
------------

// File: rtl/normalize_shifter_pkg.sv
// -----------------------------------------------------------------------------
// normalize_shifter_pkg
// Shared FPU normalization constants and beat type. The LZD tree and the
// normalize shifter both take their widths from here, so the leading-zero
// count width always matches the shifter's amount width.
//   WIDTH   - significand width (power of two)
//   CNT_W   - shift-count width, $clog2(WIDTH)
//   EXP_W   - signed exponent width
//   EXP_MIN - minimum normal exponent
// -----------------------------------------------------------------------------
package normalize_shifter_pkg;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = $clog2(WIDTH);
    localparam int EXP_W   = 10;
    localparam int EXP_MIN = -126;

    typedef struct packed {
        logic [WIDTH-1:0]        significand;
        logic signed [EXP_W-1:0] exponent;
        logic                    zero;
        logic                    denormal;
    } norm_beat_t;

endpackage

// File: rtl/normalize_shifter_norm_shift_amount.sv
// -----------------------------------------------------------------------------
// norm_shift_amount
// Combinational shift-amount calculator. Clamps the leading-zero count so the
// exponent never drops below EXP_MIN, and flags when the clamp was applied.
// Ports:
//   exponent  in   EXP_W  signed input exponent
//   lz_count  in   CNT_W  leading-zero count from the LZD
//   amt       out  CNT_W  shift amount to apply
//   denormal  out  1      result is denormal (shift limited by EXP_MIN)
// -----------------------------------------------------------------------------
module norm_shift_amount
    import normalize_shifter_pkg::*;
(
    input  logic signed [EXP_W-1:0] exponent,
    input  logic [CNT_W-1:0]        lz_count,
    output logic [CNT_W-1:0]        amt,
    output logic                    denormal
);

    localparam logic signed [EXP_W:0] EXP_MIN_X = (EXP_W+1)'(EXP_MIN);

    logic signed [EXP_W:0] headroom;
    logic signed [EXP_W:0] lz_ext;

    always_comb begin
        // One extra bit so exponent - EXP_MIN cannot overflow.
        headroom = $signed({exponent[EXP_W-1], exponent}) - EXP_MIN_X;
        lz_ext   = $signed({{(EXP_W+1-CNT_W){1'b0}}, lz_count});
        amt      = '0;
        denormal = 1'b0;
        if (headroom[EXP_W] || (headroom == '0)) begin
            // Already at or below the minimum: no shift at all.
            amt      = '0;
            denormal = 1'b1;
        end else if (lz_ext > headroom) begin
            // headroom < lz <= WIDTH-1 here, so it fits in CNT_W bits.
            amt      = headroom[CNT_W-1:0];
            denormal = 1'b1;
        end else begin
            amt      = lz_count;
            denormal = 1'b0;
        end
    end

endmodule

// File: rtl/normalize_shifter.sv
// -----------------------------------------------------------------------------
// normalize_shifter
// Two-stage normalization left shifter placed after the LZD. Stage 1 clamps
// the shift amount, adjusts the exponent and does the coarse (multiple of 8)
// shift; stage 2 does the fine (0..7) shift. Widths come from
// normalize_shifter_pkg. Valid/ready on both sides, one beat per cycle.
// Optional feature macro: NORM_STATS_EN (adds stat_clear input and saturating
// zero/denormal result counters).
// Ports:
//   clk, reset                 clock (rising), async active-high reset
//   in_valid / in_ready        input handshake
//   in_significand, in_exponent, in_lz_count, in_all_zero   input beat
//   out_valid / out_ready      output handshake
//   out_significand, out_exponent, out_zero, out_denormal   result beat
//   stat_clear, stat_zero_count, stat_denormal_count        (NORM_STATS_EN)
// -----------------------------------------------------------------------------
module normalize_shifter
    import normalize_shifter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_significand,
    input  logic signed [EXP_W-1:0] in_exponent,
    input  logic [CNT_W-1:0]        in_lz_count,
    input  logic                    in_all_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_significand,
    output logic signed [EXP_W-1:0] out_exponent,
    output logic                    out_zero,
    output logic                    out_denormal
`ifdef NORM_STATS_EN
    ,
    input  logic                    stat_clear,
    output logic [15:0]             stat_zero_count,
    output logic [15:0]             stat_denormal_count
`endif
);

    logic       s1_valid_q, s1_valid_d;
    logic       s2_valid_q, s2_valid_d;
    norm_beat_t s1_beat_q, s1_beat_d;
    norm_beat_t s2_beat_q, s2_beat_d;
    logic [2:0] s1_fine_q, s1_fine_d;

    logic             s1_adv, s2_adv, accept;
    logic [CNT_W-1:0] amt, coarse;
    logic             amt_denormal;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    norm_shift_amount u_amt (
        .exponent (in_exponent),
        .lz_count (in_lz_count),
        .amt      (amt),
        .denormal (amt_denormal)
    );

    // Coarse shift handles the byte-multiple part of the amount; the low 3
    // bits are carried to stage 2.
    assign coarse = {amt[CNT_W-1:3], 3'b000};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_beat_d  = s1_beat_q;
        s1_fine_d  = s1_fine_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            if (in_all_zero) begin
                s1_beat_d      = '0;
                s1_beat_d.zero = 1'b1;
                s1_fine_d      = '0;
            end else begin
                s1_beat_d.significand = in_significand << coarse;
                s1_beat_d.exponent    = in_exponent - $signed({{(EXP_W-CNT_W){1'b0}}, amt});
                s1_beat_d.zero        = 1'b0;
                s1_beat_d.denormal    = amt_denormal;
                s1_fine_d             = amt[2:0];
            end
        end

        s2_valid_d = s2_valid_q;
        s2_beat_d  = s2_beat_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_beat_d             = s1_beat_q;
                s2_beat_d.significand = s1_beat_q.significand << s1_fine_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_beat_q  <= '0;
            s2_beat_q  <= '0;
            s1_fine_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_beat_q  <= s1_beat_d;
            s2_beat_q  <= s2_beat_d;
            s1_fine_q  <= s1_fine_d;
        end
    end

    assign out_valid       = s2_valid_q;
    assign out_significand = s2_beat_q.significand;
    assign out_exponent    = s2_beat_q.exponent;
    assign out_zero        = s2_beat_q.zero;
    assign out_denormal    = s2_beat_q.denormal;

`ifdef NORM_STATS_EN
    logic [15:0] zero_cnt_q, zero_cnt_d;
    logic [15:0] den_cnt_q, den_cnt_d;
    logic        out_xfer;

    assign out_xfer = out_valid && out_ready;

    // Clear has priority over a same-cycle increment; counters saturate.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        den_cnt_d  = den_cnt_q;
        if (stat_clear) begin
            zero_cnt_d = '0;
            den_cnt_d  = '0;
        end else begin
            if (out_xfer && s2_beat_q.zero && (zero_cnt_q != 16'hFFFF)) begin
                zero_cnt_d = zero_cnt_q + 16'd1;
            end
            if (out_xfer && s2_beat_q.denormal && (den_cnt_q != 16'hFFFF)) begin
                den_cnt_d = den_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_cnt_q <= '0;
            den_cnt_q  <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
            den_cnt_q  <= den_cnt_d;
        end
    end

    assign stat_zero_count     = zero_cnt_q;
    assign stat_denormal_count = den_cnt_q;
`endif

endmodule

// File: tb/tb_normalize_shifter.sv
// Testbench for normalize_shifter: directed cases plus randomized traffic,
// checked against a behavioural scoreboard model.
module tb_normalize_shifter;
    import normalize_shifter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_all_zero;
    logic [31:0] in_significand;
    logic [9:0]  in_exponent;
    logic [4:0]  in_lz_count;
    logic        out_valid, out_ready, out_zero, out_denormal;
    logic [31:0] out_significand;
    logic [9:0]  out_exponent;
`ifdef NORM_STATS_EN
    logic        stat_clear;
    logic [15:0] stat_zero_count, stat_denormal_count;
`endif

    always #5 clk = ~clk;

    normalize_shifter dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_significand  (in_significand),
        .in_exponent     (in_exponent),
        .in_lz_count     (in_lz_count),
        .in_all_zero     (in_all_zero),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_significand (out_significand),
        .out_exponent    (out_exponent),
        .out_zero        (out_zero),
        .out_denormal    (out_denormal)
`ifdef NORM_STATS_EN
        ,
        .stat_clear          (stat_clear),
        .stat_zero_count     (stat_zero_count),
        .stat_denormal_count (stat_denormal_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] sig;
        logic [9:0]  e;
        logic        z;
        logic        d;
    } beat_t;

    beat_t sb[$];

    // Reference: one whole shift by the clamped amount, plain integer math.
    function automatic beat_t ref_norm(input logic [31:0] sig, input logic [9:0] e,
                                       input int lz, input logic az);
        beat_t r;
        int    ev, hr, amt;
        if (az) begin
            r.sig = '0; r.e = '0; r.z = 1'b1; r.d = 1'b0;
            return r;
        end
        ev = int'($signed(e));
        hr = ev - EXP_MIN;
        if (hr <= 0) begin
            amt = 0; r.d = 1'b1;
        end else if (lz > hr) begin
            amt = hr; r.d = 1'b1;
        end else begin
            amt = lz; r.d = 1'b0;
        end
        r.sig = sig << amt;
        r.e   = 10'(ev - amt);
        r.z   = 1'b0;
        return r;
    endfunction

    function automatic int clz(input logic [31:0] s);
        for (int i = 31; i >= 0; i--) if (s[i]) return 31 - i;
        return 31;
    endfunction

    // Monitor: scoreboard pop/compare, stall-stability and stats model.
    logic        held_vld = 1'b0;
    logic [31:0] held_sig;
    logic [9:0]  held_exp;
    logic        held_z, held_d;
    int          m_zero = 0, m_den = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (held_vld) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sig", out_significand, held_sig);
                chk("hold_exp", out_exponent, held_exp);
                chk("hold_flags", {out_zero, out_denormal}, {held_z, held_d});
            end
`ifdef NORM_STATS_EN
            chk("stat_zero", stat_zero_count, m_zero[15:0]);
            chk("stat_den", stat_denormal_count, m_den[15:0]);
            if (stat_clear) begin
                m_zero = 0; m_den = 0;
            end else if (out_valid && out_ready) begin
                if (out_zero && m_zero < 65535) m_zero++;
                if (out_denormal && m_den < 65535) m_den++;
            end
`endif
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t x;
                    x = sb.pop_front();
                    chk("sig", out_significand, x.sig);
                    chk("exp", out_exponent, x.e);
                    chk("zero", out_zero, x.z);
                    chk("denormal", out_denormal, x.d);
                end
            end
            held_vld = out_valid && !out_ready;
            held_sig = out_significand; held_exp = out_exponent;
            held_z   = out_zero;        held_d   = out_denormal;
            if (in_valid && in_ready)
                sb.push_back(ref_norm(in_significand, in_exponent, int'(in_lz_count), in_all_zero));
        end
    end

    task automatic drive(input logic [31:0] s, input logic [9:0] e, input logic [4:0] lz,
                         input logic az);
        bit acc = 1'b0;
        in_valid = 1'b1; in_significand = s; in_exponent = e; in_lz_count = lz; in_all_zero = az;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        sb.delete(); held_vld = 1'b0; m_zero = 0; m_den = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    bit rnd_done;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_all_zero = 1'b0; in_significand = '0;
        in_exponent = '0; in_lz_count = '0; out_ready = 1'b1;
`ifdef NORM_STATS_EN
        stat_clear = 1'b0;
`endif
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", {out_significand, out_exponent, out_zero, out_denormal}, 0);
        #16;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic shift with exact latency.
        drive(32'h0000_1234, 10'd0, 5'd19, 1'b0);
        @(negedge clk); chk("lat1_valid", out_valid, 0);
        @(negedge clk); chk("lat2_valid", out_valid, 1);
        chk("basic_sig", out_significand, 32'h91A0_0000);
        chk("basic_exp", out_exponent, 10'h3ED);
        chk("basic_flags", {out_zero, out_denormal}, 2'b00);
        @(posedge clk); #1;

        // Clamp at EXP_MIN.
        drive(32'h0000_0001, 10'h388, 5'd31, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("clamp_sig", out_significand, 32'h0000_0040);
        chk("clamp_exp", out_exponent, 10'h382);
        chk("clamp_flags", {out_zero, out_denormal}, 2'b01);
        @(posedge clk); #1;

        // All-zero input.
        drive(32'h0, 10'd5, 5'd7, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("zero_sig", out_significand, 32'h0);
        chk("zero_exp", out_exponent, 10'h0);
        chk("zero_flags", {out_zero, out_denormal}, 2'b10);
        @(posedge clk); #1;

        // Boundaries: exp==EXP_MIN, exp<EXP_MIN, MSB set with lz=0.
        drive(32'h0100_0000, 10'h382, 5'd7, 1'b0);
        drive(32'h0000_00FF, 10'h338, 5'd24, 1'b0);
        drive(32'h8000_0001, 10'd12, 5'd0, 1'b0);
        drain();

        // Backpressure: two beats fill the pipe, the third must wait.
        out_ready = 1'b0;
        drive(32'h8765_4321, 10'd3, 5'd0, 1'b0);
        drive(32'h4765_4321, 10'd3, 5'd1, 1'b0);
        in_valid = 1'b1; in_significand = 32'h2765_4321; in_exponent = 10'd3;
        in_lz_count = 5'd2; in_all_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("bp_in_ready", in_ready, 0); chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(32'h2765_4321, 10'd3, 5'd2, 1'b0);
        drive(32'h1765_4321, 10'd3, 5'd3, 1'b0);
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        drive(32'h00F0_0000, 10'd1, 5'd8, 1'b0);
        drive(32'h0F00_0000, 10'd1, 5'd4, 1'b0);
        #2;
        reset = 1'b1;
        sb.delete(); held_vld = 1'b0; m_zero = 0; m_den = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", {out_significand, out_exponent, out_zero, out_denormal}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("midrst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;

        // Randomized traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    logic [31:0] s;
                    logic [9:0]  e;
                    logic [4:0]  lz;
                    logic        az;
                    s  = $urandom >> $urandom_range(0, 31);
                    az = ($urandom_range(0, 15) == 0);
                    if (az) s = '0;
                    e  = ($urandom_range(0, 1) == 0) ? 10'(int'($urandom_range(0, 90)) - 150)
                                                     : 10'($urandom);
                    lz = ($urandom_range(0, 3) != 0) ? 5'(clz(s)) : 5'($urandom);
                    drive(s, e, lz, az);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

`ifdef NORM_STATS_EN
        // Counting: 3 zero beats, 2 clamped beats.
        apply_reset();
        for (int i = 0; i < 3; i++) drive(32'h0, 10'd9, 5'd0, 1'b1);
        drive(32'h0000_0003, 10'h383, 5'd30, 1'b0);
        drive(32'h0000_0010, 10'h340, 5'd27, 1'b0);
        drain();
        chk("stats_zero3", stat_zero_count, 16'd3);
        chk("stats_den2", stat_denormal_count, 16'd2);

        // Saturation: stream enough zero beats to pass 16'hFFFF.
        for (int i = 0; i < 65540; i++) drive(32'h0, 10'd0, 5'd0, 1'b1);
        drain();
        chk("stats_sat", stat_zero_count, 16'hFFFF);

        // Clear coinciding with an increment.
        drive(32'h0, 10'd0, 5'd0, 1'b1);
        @(posedge clk); #1;
        stat_clear = 1'b1;
        @(negedge clk); chk("clr_xfer_zero", {out_valid, out_zero}, 2'b11);
        @(posedge clk); #1;
        stat_clear = 1'b0;
        chk("clr_wins", stat_zero_count, 16'd0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
